boot_loader: RTL and testbench

//   Loads a program image from a byte stream into BRAM over the PicoRV32 native

---
 rtl/boot_loader.sv | 194 +++++++++++++++++++
 tb/tb_boot_loader.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: streams a length-prefixed program image into BRAM, then
// releases the CPU and hands it the BRAM port.
//
// Ports:
//   clk, reset_n       clock and asynchronous active-low reset
//   in_valid/in_ready  byte stream handshake, in_data carries the byte
//   cpu_reset_n        CPU reset, released on the edge that enters RUN
//   done / error       load finished / length too large (sticky)
//   cpu_mem_*          PicoRV32 native port from the CPU
//   ram_mem_*          native port towards the BRAM controller
module boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        cpu_reset_n,
    output logic        done,
    output logic        error,
    input  logic        cpu_mem_valid,
    input  logic        cpu_mem_instr,
    output logic        cpu_mem_ready,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic [31:0] cpu_mem_rdata,
    output logic        ram_mem_valid,
    input  logic        ram_mem_ready,
    output logic [31:0] ram_mem_addr,
    output logic [31:0] ram_mem_wdata,
    output logic [3:0]  ram_mem_wstrb,
    input  logic [31:0] ram_mem_rdata
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t state, state_nx;

    logic [15:0] n_q;
    logic [15:0] idx_q;
    logic [1:0]  cnt_q;
    logic [23:0] word_q;
    logic        wr_valid_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic [3:0]  wr_strb_q;
    logic        done_q;
    logic        run_q;
    logic        err_q;

    // The instruction flag has no meaning for the BRAM side.
    logic instr_unused;
    assign instr_unused = cpu_mem_instr;

    logic [15:0] n_full;
    logic        last_word;

    assign n_full    = {in_data, n_q[7:0]};
    assign last_word = (idx_q + 16'd1) == n_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_LEN0;
        end else begin
            state <= state_nx;
        end
    end

    // in_ready is 1 exactly in LEN0/LEN1/DATA, so in_valid alone
    // marks a transfer in those states.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        unique case (state)
            S_LEN0: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = S_LEN1;
            end
            S_LEN1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (n_full == 16'd0)
                        state_nx = S_RUN;
                    else if (32'(n_full) > MAX_WORDS)
                        state_nx = S_ERROR;
                    else
                        state_nx = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid && cnt_q == 2'd3) state_nx = S_WRITE;
            end
            S_WRITE: begin
                if (ram_mem_ready)
                    state_nx = last_word ? S_RUN : S_DATA;
            end
            S_RUN:   state_nx = S_RUN;
            S_ERROR: state_nx = S_ERROR;
            default: state_nx = S_LEN0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_q        <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            done_q     <= 1'b0;
            run_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            unique case (state)
                S_LEN0: begin
                    if (in_valid) n_q[7:0] <= in_data;
                end
                S_LEN1: begin
                    if (in_valid) begin
                        n_q[15:8] <= in_data;
                        idx_q     <= '0;
                        cnt_q     <= '0;
                    end
                end
                S_DATA: begin
                    if (in_valid) begin
                        cnt_q <= cnt_q + 2'd1;
                        unique case (cnt_q)
                            2'd0: word_q[7:0]   <= in_data;
                            2'd1: word_q[15:8]  <= in_data;
                            2'd2: word_q[23:16] <= in_data;
                            default: begin
                                // 4th byte goes straight into the write
                                wr_valid_q <= 1'b1;
                                wr_addr_q  <= BASE_ADDR
                                            + {14'd0, idx_q, 2'b00};
                                wr_data_q  <= {in_data, word_q};
                                wr_strb_q  <= 4'b1111;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (ram_mem_ready) begin
                        wr_valid_q <= 1'b0;
                        idx_q      <= idx_q + 16'd1;
                    end
                end
                default: ;
            endcase
            done_q <= (state_nx == S_RUN);
            run_q  <= (state_nx == S_RUN);
            err_q  <= (state_nx == S_ERROR);
        end
    end

    assign done        = done_q;
    assign cpu_reset_n = run_q;
    assign error       = err_q;

    // The CPU sees the RAM only once loading is complete.
    always_comb begin
        if (done_q) begin
            ram_mem_valid = cpu_mem_valid;
            ram_mem_addr  = cpu_mem_addr;
            ram_mem_wdata = cpu_mem_wdata;
            ram_mem_wstrb = cpu_mem_wstrb;
            cpu_mem_ready = ram_mem_ready;
        end else begin
            ram_mem_valid = wr_valid_q;
            ram_mem_addr  = wr_addr_q;
            ram_mem_wdata = wr_data_q;
            ram_mem_wstrb = wr_strb_q;
            cpu_mem_ready = 1'b0;
        end
    end

    assign cpu_mem_rdata = ram_mem_rdata;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: table-driven and randomized image loads checked
// against a stream-parsing reference model and a BRAM model.
module tb_boot_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int MAXW = 256;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        cpu_reset_n;
    logic        done;
    logic        error;
    logic        cpu_mem_valid;
    logic        cpu_mem_instr;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic [31:0] cpu_mem_rdata;
    logic        ram_mem_valid;
    logic        ram_mem_ready;
    logic [31:0] ram_mem_addr;
    logic [31:0] ram_mem_wdata;
    logic [3:0]  ram_mem_wstrb;
    logic [31:0] ram_mem_rdata;

    boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cpu_reset_n(cpu_reset_n), .done(done), .error(error),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr),
        .cpu_mem_ready(cpu_mem_ready), .cpu_mem_addr(cpu_mem_addr),
        .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb),
        .cpu_mem_rdata(cpu_mem_rdata),
        .ram_mem_valid(ram_mem_valid), .ram_mem_ready(ram_mem_ready),
        .ram_mem_addr(ram_mem_addr), .ram_mem_wdata(ram_mem_wdata),
        .ram_mem_wstrb(ram_mem_wstrb), .ram_mem_rdata(ram_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- BRAM model ----------------
    logic [31:0] mem [0:1023];
    logic        ram_rdy;
    int          ram_delay;
    int          wcnt;
    int          vcnt;
    int          early;
    logic [31:0] mw;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    time         last_ack_t;
    time         last_byte_t;
    time         rise_t;

    assign ram_mem_ready = ram_rdy;
    assign ram_mem_rdata = mem[ram_mem_addr[11:2]];

    always @(posedge clk) begin
        if (reset_n && ram_mem_valid && !done) vcnt++;
        if (reset_n && !done && cpu_mem_ready) early++;
        if (!reset_n) begin
            ram_rdy <= 1'b0;
            wcnt    <= 0;
        end else if (ram_mem_valid && ram_rdy) begin
            mw = mem[ram_mem_addr[11:2]];
            for (int k = 0; k < 4; k++)
                if (ram_mem_wstrb[k]) mw[8*k +: 8] = ram_mem_wdata[8*k +: 8];
            mem[ram_mem_addr[11:2]] <= mw;
            if (!done) begin
                log_addr.push_back(ram_mem_addr);
                log_data.push_back(ram_mem_wdata);
                last_ack_t = $time;
            end
            ram_rdy <= 1'b0;
            wcnt    <= 0;
        end else if (ram_mem_valid) begin
            if (wcnt >= ram_delay) ram_rdy <= 1'b1;
            else wcnt <= wcnt + 1;
        end else begin
            ram_rdy <= 1'b0;
            wcnt    <= 0;
        end
    end

    always @(posedge cpu_reset_n) rise_t = $time;

    // A pending write request must not change until it is accepted.
    logic        pend;
    logic [31:0] pa, pd;
    logic [3:0]  ps;
    initial pend = 1'b0;
    always @(posedge clk) begin
        if (reset_n && pend && !done) begin
            checks++;
            if (ram_mem_valid !== 1'b1 || ram_mem_addr !== pa ||
                ram_mem_wdata !== pd || ram_mem_wstrb !== ps) begin
                errors++;
                $display("FAIL hold: got v=%b a=%h d=%h s=%h expected v=1 a=%h d=%h s=%h",
                         ram_mem_valid, ram_mem_addr, ram_mem_wdata,
                         ram_mem_wstrb, pa, pd, ps);
            end
        end
        pend = reset_n && ram_mem_valid && !ram_mem_ready && !done;
        pa = ram_mem_addr;
        pd = ram_mem_wdata;
        ps = ram_mem_wstrb;
    end

    // ---------------- reference model ----------------
    logic [7:0]  stream[$];
    int          m_n;
    bit          m_err;
    int          m_nb;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic model();
        m_n   = int'(stream[0]) + 256 * int'(stream[1]);
        m_err = m_n > MAXW;
        m_nb  = m_err ? 2 : 2 + 4 * m_n;
        exp_addr.delete();
        exp_data.delete();
        if (!m_err)
            for (int i = 0; i < m_n; i++) begin
                exp_addr.push_back(BASE + 32'(4 * i));
                exp_data.push_back({stream[2+4*i+3], stream[2+4*i+2],
                                    stream[2+4*i+1], stream[2+4*i]});
            end
    endtask

    task automatic build_stream(input int n);
        stream.delete();
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        for (int i = 0; i < ((n <= MAXW) ? 4 * n : 8); i++)
            stream.push_back(8'($urandom));
    endtask

    // ---------------- drivers ----------------
    task automatic send_bytes(input int nb, input int gap);
        int c;
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, gap)) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = stream[i];
            c = 0;
            while (!in_ready && c < 300) begin
                @(negedge clk);
                c++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL in_ready_wait: byte %0d got in_ready=0 expected 1", i);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            last_byte_t = $time;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic apply_reset(input bit chk_vals);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        if (chk_vals) begin
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_error", 32'(error), 32'd0);
            chk("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
            chk("rst_valid", 32'(ram_mem_valid), 32'd0);
            chk("rst_addr", ram_mem_addr, 32'd0);
            chk("rst_wdata", ram_mem_wdata, 32'd0);
            chk("rst_wstrb", 32'(ram_mem_wstrb), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        if (chk_vals) chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic run_image(input bit rst_first, input int dly,
                             input int gap, input bit exp_done,
                             input bit exp_err);
        int c;
        if (rst_first) apply_reset(1'b0);
        ram_delay = dly;
        log_addr.delete();
        log_data.delete();
        vcnt = 0;
        rise_t = 0;
        last_ack_t = 0;
        model();
        send_bytes(m_nb, gap);
        c = 0;
        while (!(done || error) && c < 4000) begin
            @(negedge clk);
            c++;
        end
        chk("done", 32'(done), 32'(exp_done));
        chk("error", 32'(error), 32'(exp_err));
        chk("cpu_reset_n", 32'(cpu_reset_n), 32'(exp_done));
        chk("n_writes", 32'(log_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            chk("wr_addr", log_addr[i], exp_addr[i]);
            chk("wr_data", log_data[i], exp_data[i]);
        end
        if (exp_done)
            chk("rst_rise_time", 32'(rise_t),
                32'((m_n == 0) ? last_byte_t : last_ack_t));
        else
            chk("rst_no_rise", 32'(rise_t), 32'd0);
        if (m_n == 0 || m_err) chk("valid_cycles", 32'(vcnt), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h5a;
        c = 0;
        repeat (4) begin
            if (in_ready) c++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("extra_bytes", 32'(c), 32'd0);
    endtask

    task automatic cpu_access(input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, output logic [31:0] rd);
        int c;
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = a;
        cpu_mem_wdata = wd;
        cpu_mem_wstrb = ws;
        #1;
        chk("pt_valid", 32'(ram_mem_valid), 32'd1);
        chk("pt_addr", ram_mem_addr, a);
        chk("pt_wdata", ram_mem_wdata, wd);
        chk("pt_wstrb", 32'(ram_mem_wstrb), 32'(ws));
        c = 0;
        while (!cpu_mem_ready && c < 50) begin
            chk("rdy_follow", 32'(cpu_mem_ready), 32'(ram_rdy));
            @(negedge clk);
            c++;
        end
        chk("cpu_ready", 32'(cpu_mem_ready), 32'd1);
        rd = cpu_mem_rdata;
        @(posedge clk);
        @(negedge clk);
        cpu_mem_valid = 1'b0;
        cpu_mem_wstrb = 4'h0;
    endtask

    // ---------------- test sequence ----------------
    typedef struct {
        int n;
        bit exp_done;
        bit exp_err;
    } vec_t;

    vec_t        tbl[8];
    logic [31:0] rd;
    int          rn;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h0;
        cpu_mem_valid = 1'b0;
        cpu_mem_instr = 1'b0;
        cpu_mem_addr = 32'h0;
        cpu_mem_wdata = 32'h0;
        cpu_mem_wstrb = 4'h0;
        ram_delay = 0;
        vcnt = 0;
        early = 0;
        rise_t = 0;
        last_ack_t = 0;
        last_byte_t = 0;

        tbl[0] = '{0,      1'b1, 1'b0};
        tbl[1] = '{1,      1'b1, 1'b0};
        tbl[2] = '{5,      1'b1, 1'b0};
        tbl[3] = '{256,    1'b1, 1'b0};
        tbl[4] = '{257,    1'b0, 1'b1};
        tbl[5] = '{512,    1'b0, 1'b1};
        tbl[6] = '{65535,  1'b0, 1'b1};
        tbl[7] = '{2,      1'b1, 1'b0};

        repeat (2) @(negedge clk);
        apply_reset(1'b1);

        // three-instruction image from the bring-up program
        stream = '{8'h03, 8'h00,
                   8'h93, 8'h00, 8'ha0, 8'h00,
                   8'h33, 8'h81, 8'h10, 8'h00,
                   8'hb3, 8'h81, 8'h20, 8'h00};
        run_image(1'b1, 0, 0, 1'b1, 1'b0);
        chk("ram0", mem[0], 32'h00a00093);
        chk("ram1", mem[1], 32'h00108133);
        chk("ram2", mem[2], 32'h002081b3);

        // CPU owns the memory now
        ram_delay = 2;
        cpu_access(32'h4, 32'h0, 4'h0, rd);
        chk("cpu_read", rd, 32'h00108133);
        cpu_access(32'h80, 32'hdeadbeef, 4'hf, rd);
        chk("cpu_write", mem[32], 32'hdeadbeef);

        for (int i = 0; i < 8; i++) begin
            build_stream(tbl[i].n);
            run_image(1'b1, i % 4, i % 3, tbl[i].exp_done, tbl[i].exp_err);
        end

        // slow RAM, bursty stream, CPU request held during the load
        build_stream(6);
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = 32'h200;
        cpu_mem_wdata = 32'h12345678;
        cpu_mem_wstrb = 4'hf;
        run_image(1'b1, 3, 3, 1'b1, 1'b0);
        cpu_mem_valid = 1'b0;
        cpu_mem_wstrb = 4'h0;

        // reset while word 2 of 5 is waiting for the RAM
        apply_reset(1'b0);
        build_stream(5);
        ram_delay = 3;
        log_addr.delete();
        log_data.delete();
        send_bytes(10, 0);
        chk("mid_valid", 32'(ram_mem_valid), 32'd1);
        chk("mid_addr", ram_mem_addr, BASE + 32'h4);
        chk("mid_logged", 32'(log_addr.size()), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ram_mem_valid), 32'd0);
        chk("mid_rst_addr", ram_mem_addr, 32'd0);
        chk("mid_rst_wdata", ram_mem_wdata, 32'd0);
        chk("mid_rst_wstrb", 32'(ram_mem_wstrb), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_cpu", 32'(cpu_reset_n), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        build_stream(2);
        run_image(1'b0, 1, 1, 1'b1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            rn = $urandom_range(0, 300);
            build_stream(rn);
            run_image(1'b1, $urandom_range(0, 3), $urandom_range(0, 2),
                      rn <= MAXW, rn > MAXW);
        end

        chk("cpu_ready_outside_run", 32'(early), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
